// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: holds the retiring instruction, waits for
// load data from data memory, extends sub-word loads and drives the register file write port.
module wb_stage #(
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wb_valid_i,
  input  logic              mem_wb_we_i,
  input  logic [REG_AW-1:0] mem_wb_waddr_i,
  input  logic [31:0]       mem_wb_result_i,
  input  logic              mem_wb_load_i,
  input  logic [2:0]        mem_wb_load_type_i,
  input  logic [1:0]        mem_wb_addr_lo_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              wb_stall_i,
  input  logic              wb_flush_i,
  output logic              wb_stall_req_o,
  output logic              wb_regfile_we_o,
  output logic [REG_AW-1:0] wb_regfile_waddr_o,
  output logic [31:0]       wb_regfile_wdata_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic              r_valid_q;
  logic              r_we_q;
  logic [REG_AW-1:0] r_waddr_q;
  logic [31:0]       r_result_q;
  logic              r_load_q;
  logic [2:0]        r_load_type_q;
  logic [1:0]        r_addr_lo_q;
  logic [31:0]       d_q, d_d;

  logic              advance;
  logic              capture_valid;
  logic [1:0]        lane;
  logic              half_hi;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       ext_data;

  assign advance       = (state_q != StWait) && !wb_stall_i;
  assign capture_valid = mem_wb_valid_i && !wb_flush_i;

  // Lane index below is little-endian; big-endian memory mirrors it.
  assign lane    = BIG_ENDIAN ? ~r_addr_lo_q : r_addr_lo_q;
  assign half_hi = BIG_ENDIAN ? ~r_addr_lo_q[1] : r_addr_lo_q[1];
  assign rhalf   = half_hi ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    rbyte = mem_rdata_i[7:0];
    unique case (lane)
      2'd0: rbyte = mem_rdata_i[7:0];
      2'd1: rbyte = mem_rdata_i[15:8];
      2'd2: rbyte = mem_rdata_i[23:16];
      2'd3: rbyte = mem_rdata_i[31:24];
      default: rbyte = mem_rdata_i[7:0];
    endcase
  end

  always_comb begin
    ext_data = mem_rdata_i;
    case (r_load_type_q)
      3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext_data = {24'h0, rbyte};
      3'b010:  ext_data = {{16{rhalf[15]}}, rhalf};
      3'b011:  ext_data = {16'h0, rhalf};
      default: ext_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    if (advance) begin
      state_d = (capture_valid && mem_wb_load_i) ? StWait : StIdle;
    end else if (state_q == StWait && mem_rvalid_i) begin
      state_d = StDone;
      d_d     = ext_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      d_q           <= '0;
      r_valid_q     <= 1'b0;
      r_we_q        <= 1'b0;
      r_waddr_q     <= '0;
      r_result_q    <= '0;
      r_load_q      <= 1'b0;
      r_load_type_q <= '0;
      r_addr_lo_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      if (advance) begin
        r_valid_q     <= capture_valid;
        r_we_q        <= mem_wb_we_i;
        r_waddr_q     <= mem_wb_waddr_i;
        r_result_q    <= mem_wb_result_i;
        r_load_q      <= mem_wb_load_i;
        r_load_type_q <= mem_wb_load_type_i;
        r_addr_lo_q   <= mem_wb_addr_lo_i;
      end
    end
  end

  always_comb begin
    wb_stall_req_o     = (state_q == StWait);
    wb_regfile_we_o    = r_valid_q && r_we_q && (r_waddr_q != '0) &&
                         (!r_load_q || state_q == StDone);
    wb_regfile_waddr_o = r_valid_q ? r_waddr_q : '0;
    wb_regfile_wdata_o = '0;
    if (state_q == StDone) begin
      wb_regfile_wdata_o = d_q;
    end else if (r_valid_q) begin
      wb_regfile_wdata_o = r_result_q;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (big-endian lane order, 5-bit register addresses).
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_wb_valid_i;
  logic        mem_wb_we_i;
  logic [4:0]  mem_wb_waddr_i;
  logic [31:0] mem_wb_result_i;
  logic        mem_wb_load_i;
  logic [2:0]  mem_wb_load_type_i;
  logic [1:0]  mem_wb_addr_lo_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_stall_i;
  logic        wb_flush_i;
  logic        wb_stall_req_o;
  logic        wb_regfile_we_o;
  logic [4:0]  wb_regfile_waddr_o;
  logic [31:0] wb_regfile_wdata_o;

  int unsigned n_checks;
  int unsigned n_pass;

  wb_stage #(
    .BIG_ENDIAN(1'b1),
    .REG_AW    (5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_wb_valid_i    (mem_wb_valid_i),
    .mem_wb_we_i       (mem_wb_we_i),
    .mem_wb_waddr_i    (mem_wb_waddr_i),
    .mem_wb_result_i   (mem_wb_result_i),
    .mem_wb_load_i     (mem_wb_load_i),
    .mem_wb_load_type_i(mem_wb_load_type_i),
    .mem_wb_addr_lo_i  (mem_wb_addr_lo_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .wb_stall_i        (wb_stall_i),
    .wb_flush_i        (wb_flush_i),
    .wb_stall_req_o    (wb_stall_req_o),
    .wb_regfile_we_o   (wb_regfile_we_o),
    .wb_regfile_waddr_o(wb_regfile_waddr_o),
    .wb_regfile_wdata_o(wb_regfile_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Check the whole write port plus the stall request in one go.
  task automatic check_port(input string tag, input logic stall, input logic we,
                            input logic [4:0] waddr, input logic [31:0] wdata);
    check({tag, ".stall"}, {31'h0, wb_stall_req_o}, {31'h0, stall});
    check({tag, ".we"}, {31'h0, wb_regfile_we_o}, {31'h0, we});
    check({tag, ".waddr"}, {27'h0, wb_regfile_waddr_o}, {27'h0, waddr});
    check({tag, ".wdata"}, wb_regfile_wdata_o, wdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic we, input logic [4:0] waddr,
                       input logic [31:0] result, input logic load, input logic [2:0] ltype,
                       input logic [1:0] addr_lo);
    mem_wb_valid_i     = valid;
    mem_wb_we_i        = we;
    mem_wb_waddr_i     = waddr;
    mem_wb_result_i    = result;
    mem_wb_load_i      = load;
    mem_wb_load_type_i = ltype;
    mem_wb_addr_lo_i   = addr_lo;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0);
  endtask

  // Load with data returning one cycle after capture.
  task automatic do_load(input string tag, input logic [2:0] ltype, input logic [1:0] addr_lo,
                         input logic [31:0] rdata, input logic [4:0] waddr,
                         input logic [31:0] exp);
    drive(1'b1, 1'b1, waddr, 32'h5555_5555, 1'b1, ltype, addr_lo);
    step();
    check_port({tag, ".wait"}, 1'b1, 1'b0, waddr, 32'h5555_5555);
    drive_idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    step();
    check_port({tag, ".done"}, 1'b0, 1'b1, waddr, exp);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    step();
    check_port({tag, ".after"}, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    wb_stall_i   = 1'b0;
    wb_flush_i   = 1'b0;
    drive_idle();

    #2;
    check_port("reset_low", 1'b0, 1'b0, 5'd0, 32'h0);
    #10 rst = 1'b1;
    #1;
    check_port("post_release", 1'b0, 1'b0, 5'd0, 32'h0);

    // ADD r5 and an asynchronous reset in the middle of the following cycle.
    drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'd0, 2'd0);
    step();
    check_port("add_r5", 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    drive_idle();
    #2 rst = 1'b0;
    #1;
    check_port("async_rst", 1'b0, 1'b0, 5'd0, 32'h0);
    #2 rst = 1'b1;

    // LB, rvalid three cycles after capture, followed by a held ADD r8.
    drive(1'b1, 1'b1, 5'd7, 32'h0, 1'b1, 3'b000, 2'd2);
    step();
    check("lb3.stall1", {31'h0, wb_stall_req_o}, 32'h1);
    check("lb3.we1", {31'h0, wb_regfile_we_o}, 32'h0);
    drive(1'b1, 1'b1, 5'd8, 32'h0000_0055, 1'b0, 3'd0, 2'd0);
    step();
    check("lb3.stall2", {31'h0, wb_stall_req_o}, 32'h1);
    step();
    check("lb3.stall3", {31'h0, wb_stall_req_o}, 32'h1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1122_83FF;
    step();
    check_port("lb3.done", 1'b0, 1'b1, 5'd7, 32'hFFFF_FF83);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    step();
    check_port("lb3.next_add", 1'b0, 1'b1, 5'd8, 32'h0000_0055);
    drive_idle();
    step();

    do_load("lbu", 3'b001, 2'd2, 32'h1122_83FF, 5'd7,  32'h0000_0083);
    do_load("lb0", 3'b000, 2'd0, 32'h9ABC_0001, 5'd3,  32'hFFFF_FF9A);
    do_load("lh",  3'b010, 2'd0, 32'h9ABC_0001, 5'd6,  32'hFFFF_9ABC);
    do_load("lhu", 3'b011, 2'd0, 32'h9ABC_0001, 5'd6,  32'h0000_9ABC);
    do_load("lh2", 3'b010, 2'd3, 32'h9ABC_8001, 5'd6,  32'hFFFF_8001);
    do_load("lw",  3'b100, 2'd3, 32'h9ABC_0001, 5'd9,  32'h9ABC_0001);
    do_load("lw7", 3'b111, 2'd1, 32'h0102_0304, 5'd9,  32'h0102_0304);

    // Write to r0 is suppressed.
    drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
    step();
    check("r0.we", {31'h0, wb_regfile_we_o}, 32'h0);

    // Flush on advance discards the captured instruction.
    drive(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 3'd0, 2'd0);
    wb_flush_i = 1'b1;
    step();
    check_port("flush_adv", 1'b0, 1'b0, 5'd0, 32'h0);
    wb_flush_i = 1'b0;

    // Flush held during WAIT leaves the pending load alone.
    drive(1'b1, 1'b1, 5'd10, 32'h0, 1'b1, 3'b100, 2'd0);
    step();
    check("flush_wait.stall", {31'h0, wb_stall_req_o}, 32'h1);
    drive(1'b1, 1'b1, 5'd11, 32'h0000_0011, 1'b0, 3'd0, 2'd0);
    wb_flush_i = 1'b1;
    step();
    check("flush_wait.stall2", {31'h0, wb_stall_req_o}, 32'h1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    step();
    check_port("flush_wait.done", 1'b0, 1'b1, 5'd10, 32'hCAFE_F00D);
    wb_flush_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    step();
    check_port("flush_wait.next", 1'b0, 1'b1, 5'd11, 32'h0000_0011);

    // Stray read data in IDLE is ignored.
    drive_idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    step();
    check_port("stray_rvalid", 1'b0, 1'b0, 5'd0, 32'h0);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;

    // Hazard stall repeats the same write; MEM inputs are not captured.
    drive(1'b1, 1'b1, 5'd12, 32'h0000_ABCD, 1'b0, 3'd0, 2'd0);
    step();
    check_port("hold.w0", 1'b0, 1'b1, 5'd12, 32'h0000_ABCD);
    drive(1'b1, 1'b1, 5'd13, 32'h0000_0777, 1'b0, 3'd0, 2'd0);
    wb_stall_i = 1'b1;
    step();
    check_port("hold.w1", 1'b0, 1'b1, 5'd12, 32'h0000_ABCD);
    step();
    check_port("hold.w2", 1'b0, 1'b1, 5'd12, 32'h0000_ABCD);
    wb_stall_i = 1'b0;
    step();
    check_port("hold.release", 1'b0, 1'b1, 5'd13, 32'h0000_0777);

    // Reset in the middle of a load abandons it.
    drive(1'b1, 1'b1, 5'd14, 32'h0, 1'b1, 3'b000, 2'd0);
    step();
    check("rst_load.stall", {31'h0, wb_stall_req_o}, 32'h1);
    drive_idle();
    rst = 1'b0;
    #1;
    check_port("rst_load.reset", 1'b0, 1'b0, 5'd0, 32'h0);
    #2 rst = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h8000_0000;
    step();
    check_port("rst_load.ignored", 1'b0, 1'b0, 5'd0, 32'h0);
    mem_rvalid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage and MEM/WB pipeline register for the 5-stage MIPS core.
- Captures results leaving MEM, waits for load data returned by data memory, and sign- or zero-extends sub-word loads.
- Drives the write port of the ID-stage register file: we, waddr, wdata.
- Holds the pipeline via a stall request while a load's data is outstanding.

Parameters:
BIG_ENDIAN, 1, byte lane order for sub-word loads (1: byte 0 = bits 31:24; 0: byte 0 = bits 7:0)
REG_AW, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (rst==0 resets)
mem_wb_valid_i  in  1  MEM presents an instruction this cycle
mem_wb_we_i  in  1  instruction writes a GPR
mem_wb_waddr_i  in  REG_AW  destination register
mem_wb_result_i  in  32  ALU/move result (non-load data)
mem_wb_load_i  in  1  instruction is a load
mem_wb_load_type_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, others treated as LW
mem_wb_addr_lo_i  in  2  effective address bits 1:0
mem_rvalid_i  in  1  data memory read data valid
mem_rdata_i  in  32  data memory read data
wb_stall_i  in  1  hazard-unit hold: stage register keeps contents
wb_flush_i  in  1  discard instruction being captured from MEM
wb_stall_req_o  out  1  WB cannot accept a new instruction
wb_regfile_we_o  out  1  register file write enable
wb_regfile_waddr_o  out  REG_AW  register file write address
wb_regfile_wdata_o  out  32  register file write data

Behaviour:
- Reset (rst low, asynchronous):
  - Stage register R (valid, we, waddr, result, load, load_type, addr_lo) cleared.
  - Load buffer D cleared; FSM goes to IDLE.
  - All outputs 0 while rst low and on the first cycle after release.
  - A reset mid-load abandons the load; a later mem_rvalid_i is ignored.
- FSM states:
  - IDLE: R empty or holds a non-load.
  - WAIT: R holds a load; data not yet received.
  - DONE: R holds a load; extended data held in D.
- advance = !wb_stall_req_o && !wb_stall_i.
- On advance, R captures the MEM inputs. If wb_flush_i or !mem_wb_valid_i, R.valid<=0 and other fields are don't-care.
- wb_flush_i never affects the instruction already in R. Flush while not advancing has no effect.
- Next state on advance: captured valid load -> WAIT; otherwise -> IDLE.
- Without advance, the state holds, except WAIT -> DONE when mem_rvalid_i=1. In that case D <= extended mem_rdata_i per R.load_type/R.addr_lo.
- mem_rvalid_i is ignored outside WAIT.
- wb_stall_req_o = (state==WAIT), combinational from state.
- wb_regfile_we_o = R.valid && R.we && R.waddr!=0 && (!R.load || state==DONE).
- wb_regfile_waddr_o = R.waddr when R.valid, else 0.
- wb_regfile_wdata_o = D in DONE, else R.result when R.valid, else 0.
- Latency:
  - Non-load: written in the cycle after capture.
  - Load: written in the cycle after the mem_rvalid_i cycle; minimum 2 cycles after capture.
- Under wb_stall_i the same write is re-asserted each cycle. This is idempotent and permitted.
- Extension (BIG_ENDIAN=1):
  - Byte lane k = addr_lo, taken from bits (31-8k):(24-8k).
  - Halfword from bits 31:16 if addr_lo[1]==0, else 15:0; addr_lo[0] ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW ignores addr_lo.
  - BIG_ENDIAN=0 mirrors the lane order.
- Register 0 is never written. we is forced low even if mem_wb_we_i=1.
- Back-to-back non-loads write one per cycle with no bubbles.
- A load followed by any instruction stalls MEM for the duration of WAIT.

Test Plan:
- Reset then ADD result 0x0000_1234 to r5 -> next cycle we=1, waddr=5, wdata=0x0000_1234; asserting rst low mid-cycle -> all outputs 0 immediately.
- LB, addr_lo=2, rdata 0x1122_83FF, rvalid 3 cycles after capture -> wb_stall_req_o high 3 cycles; then we=1, wdata=0xFFFF_FF83; LBU same -> 0x0000_0083.
- LH/LHU, addr_lo=0, rdata 0x9ABC_0001 -> 0xFFFF_9ABC / 0x0000_9ABC; LW, addr_lo=3 -> 0x9ABC_0001 unchanged.
- Write to r0 (we=1, result 0xDEAD_BEEF) -> wb_regfile_we_o stays 0.
- wb_flush_i with a valid instruction on advance -> no write next cycle; flush while in WAIT -> pending load still completes and writes.
- Stray mem_rvalid_i in IDLE with 0xFFFF_FFFF -> ignored; wb_stall_i held 2 cycles on a non-load -> identical write repeated, R unchanged.
